// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, lamp patterns and display constants
// for the traffic_ctrl intersection sequencer.
package traffic_pkg;

  // Phase index doubles as the state encoding (shown on num_6).
  typedef enum logic [2:0] {
    AR_A  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_B  = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    FLASH = 3'd6
  } state_e;

  // Lamp bits are {red, yellow, green}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Any code 4'hA..4'hF blanks a digit at the display driver.
  localparam logic [3:0] DIGIT_BLANK = 4'hA;

  // Seconds value, 0..99.
  typedef logic [6:0] sec_t;

endpackage

// File: rtl/traffic_ctrl_if.sv
// traffic_ctrl_if: control input and lamp/display outputs of traffic_ctrl.
// Optional `night` signal exists only with TRAFFIC_NIGHT_FLASH_EN.
interface traffic_ctrl_if;
  logic       hold;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic       night;
`endif
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [3:0] num_1;
  logic [3:0] num_2;
  logic [3:0] num_3;
  logic [3:0] num_4;
  logic [3:0] num_5;
  logic [3:0] num_6;

`ifdef TRAFFIC_NIGHT_FLASH_EN
  modport master (output hold, night,
                  input  ns_light, ew_light, num_1, num_2, num_3, num_4, num_5, num_6);
  modport slave  (input  hold, night,
                  output ns_light, ew_light, num_1, num_2, num_3, num_4, num_5, num_6);
`else
  modport master (output hold,
                  input  ns_light, ew_light, num_1, num_2, num_3, num_4, num_5, num_6);
  modport slave  (input  hold,
                  output ns_light, ew_light, num_1, num_2, num_3, num_4, num_5, num_6);
`endif
endinterface

// File: rtl/traffic_ctrl_bin2bcd.sv
// bin2bcd_99: 0..99 binary to two BCD digits; a zero tens digit is blanked.
module bin2bcd_99
  import traffic_pkg::*;
(
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);
  logic [3:0] tens;

  // Constant divide/modulo; inputs never exceed 99 so 4-bit results suffice.
  always_comb begin
    tens    = 4'(bin_i / 7'd10);
    units_o = 4'(bin_i % 7'd10);
    tens_o  = (tens == 4'd0) ? DIGIT_BLANK : tens;
  end
endmodule

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-way intersection sequencer on the 1 kHz display clock.
// Optional night flashing mode: define TRAFFIC_NIGHT_FLASH_EN.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_HZ   = 1000,
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2
) (
  input  logic          CLK1K,
  input  logic          rst_n,
  traffic_ctrl_if.slave bus
);
  generate
    if (CLK_HZ < 1 || T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1 ||
        (2*T_ALLRED + T_GREEN + T_YELLOW) > 99) begin : g_bad_cfg
      $error("traffic_ctrl: illegal phase length configuration");
    end
  endgenerate

  localparam int             PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(CLK_HZ - 1);
  localparam sec_t           LEN_G   = sec_t'(T_GREEN);
  localparam sec_t           LEN_Y   = sec_t'(T_YELLOW);
  localparam sec_t           LEN_A   = sec_t'(T_ALLRED);

  function automatic sec_t len_of(state_e s);
    case (s)
      NS_G, EW_G: return LEN_G;
      NS_Y, EW_Y: return LEN_Y;
      default:    return LEN_A;
    endcase
  endfunction

  state_e        state_q, state_d, nxt;
  sec_t          rem_q, rem_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic          blank_all;
  logic          blink;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic          blink_q, blink_d;
`endif

  // State, countdown and prescaler registers.
  always_ff @(posedge CLK1K or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= AR_A;
      rem_q   <= LEN_A;
      pre_q   <= '0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      blink_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pre_q   <= pre_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      blink_q <= blink_d;
`endif
    end
  end

  // Next state: prescaler, per-second countdown and phase advance.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pre_d   = pre_q;
    tick    = (pre_q == PRE_MAX) && !bus.hold;
    case (state_q)
      AR_A:    nxt = NS_G;
      NS_G:    nxt = NS_Y;
      NS_Y:    nxt = AR_B;
      AR_B:    nxt = EW_G;
      EW_G:    nxt = EW_Y;
      default: nxt = AR_A;
    endcase
    if (!bus.hold) pre_d = tick ? '0 : pre_q + 1'b1;
    if (tick) begin
      if (rem_q > 7'd1) begin
        rem_d = rem_q - 7'd1;
      end else begin
        state_d = nxt;
        rem_d   = len_of(nxt);
      end
    end
`ifdef TRAFFIC_NIGHT_FLASH_EN
    blink_d = blink_q;
    if (state_q == FLASH) begin
      // Flashing ignores hold; the prescaler only paces the blink.
      state_d = FLASH;
      rem_d   = rem_q;
      pre_d   = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
      if (pre_q == PRE_MAX) blink_d = ~blink_q;
      if (!bus.night) begin
        state_d = AR_A;
        rem_d   = LEN_A;
        pre_d   = '0;
      end
    end else if (bus.night) begin
      state_d = FLASH;
      blink_d = 1'b1;
    end
`endif
  end

`ifdef TRAFFIC_NIGHT_FLASH_EN
  assign blink     = blink_q;
  assign blank_all = (state_q == FLASH);
`else
  assign blink     = 1'b0;
  assign blank_all = 1'b0;
`endif

  sec_t       ns_v, ew_v;
  logic [3:0] ns_t, ns_u, ew_t, ew_u;

  // Lamp decode and "seconds until own green" for the red direction.
  always_comb begin
    bus.ns_light = LAMP_R;
    bus.ew_light = LAMP_R;
    ns_v = rem_q;
    ew_v = rem_q;
    case (state_q)
      AR_A: ew_v = rem_q + LEN_G + LEN_Y + LEN_A;
      NS_G: begin bus.ns_light = LAMP_G; ew_v = rem_q + LEN_Y + LEN_A; end
      NS_Y: begin bus.ns_light = LAMP_Y; ew_v = rem_q + LEN_A; end
      AR_B: ns_v = rem_q + LEN_G + LEN_Y + LEN_A;
      EW_G: begin bus.ew_light = LAMP_G; ns_v = rem_q + LEN_Y + LEN_A; end
      EW_Y: begin bus.ew_light = LAMP_Y; ns_v = rem_q + LEN_A; end
      default: begin
        bus.ns_light = blink ? LAMP_Y : LAMP_OFF;
        bus.ew_light = blink ? LAMP_Y : LAMP_OFF;
      end
    endcase
  end

  bin2bcd_99 u_ns_bcd (.bin_i(ns_v), .tens_o(ns_t), .units_o(ns_u));
  bin2bcd_99 u_ew_bcd (.bin_i(ew_v), .tens_o(ew_t), .units_o(ew_u));

  assign bus.num_1 = blank_all ? DIGIT_BLANK : ns_u;
  assign bus.num_2 = blank_all ? DIGIT_BLANK : ns_t;
  assign bus.num_3 = DIGIT_BLANK;
  assign bus.num_4 = blank_all ? DIGIT_BLANK : ew_u;
  assign bus.num_5 = blank_all ? DIGIT_BLANK : ew_t;
  assign bus.num_6 = blank_all ? DIGIT_BLANK : {1'b0, state_q};
endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: table vectors plus scoreboarded sequences for traffic_ctrl
// with CLK_HZ=4, T_GREEN=5, T_YELLOW=2, T_ALLRED=1 (16 s / 64 clock cycle).
module tb_traffic_ctrl;
  logic CLK1K = 1'b0;
  logic rst_n;
  traffic_ctrl_if bus();

  traffic_ctrl #(.CLK_HZ(4), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1)) dut (
    .CLK1K(CLK1K), .rst_n(rst_n), .bus(bus)
  );

  always #5 CLK1K = ~CLK1K;

  typedef struct {
    int         ph;
    logic [2:0] ns;
    logic [2:0] ew;
    int         nsv;
    int         ewv;
  } exp_t;

  typedef struct {
    int   adv;
    logic hold;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   eff   = 0;

  function automatic logic [3:0] dig_t(int v);
    return (v / 10 == 0) ? 4'hA : 4'(v / 10);
  endfunction
  function automatic logic [3:0] dig_u(int v);
    return 4'(v % 10);
  endfunction

  // Closed-form model: phase and displays from elapsed seconds in the 16 s cycle.
  function automatic exp_t model(int n);
    exp_t e;
    int s = (n / 4) % 16;
    if (s == 0)       e = '{0, 3'b100, 3'b100, 1 - s,  9 - s};
    else if (s <= 5)  e = '{1, 3'b001, 3'b100, 6 - s,  9 - s};
    else if (s <= 7)  e = '{2, 3'b010, 3'b100, 8 - s,  9 - s};
    else if (s == 8)  e = '{3, 3'b100, 3'b100, 17 - s, 9 - s};
    else if (s <= 13) e = '{4, 3'b100, 3'b001, 17 - s, 14 - s};
    else              e = '{5, 3'b100, 3'b010, 17 - s, 16 - s};
    return e;
  endfunction

  task automatic clk_n(int n);
    repeat (n) @(negedge CLK1K);
  endtask

  task automatic check(string nm);
    exp_t e;
    logic [29:0] g, x;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    x = {e.ns, e.ew, 4'(e.ph), dig_t(e.ewv), dig_u(e.ewv), 4'hA, dig_t(e.nsv), dig_u(e.nsv)};
    g = {bus.ns_light, bus.ew_light, bus.num_6, bus.num_5, bus.num_4,
         bus.num_3, bus.num_2, bus.num_1};
    if (g !== x) begin
      bad++;
      $display("FAIL %s (eff=%0d): got=%h want=%h", nm, eff, g, x);
    end
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{0,  1'b0, '{0, 3'b100, 3'b100, 1, 9}};
    vt[1] = '{3,  1'b0, '{0, 3'b100, 3'b100, 1, 9}};
    vt[2] = '{1,  1'b0, '{1, 3'b001, 3'b100, 5, 8}};
    vt[3] = '{4,  1'b0, '{1, 3'b001, 3'b100, 4, 7}};
    vt[4] = '{16, 1'b0, '{2, 3'b010, 3'b100, 2, 3}};
    vt[5] = '{4,  1'b0, '{2, 3'b010, 3'b100, 1, 2}};
    vt[6] = '{4,  1'b0, '{3, 3'b100, 3'b100, 9, 1}};
    vt[7] = '{4,  1'b0, '{4, 3'b100, 3'b001, 8, 5}};
    vt[8] = '{20, 1'b0, '{5, 3'b100, 3'b010, 3, 2}};
    vt[9] = '{8,  1'b0, '{0, 3'b100, 3'b100, 1, 9}};

    rst_n    = 1'b0;
    bus.hold = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    bus.night = 1'b0;
`endif
    clk_n(2);
    sb.push_back('{0, 3'b100, 3'b100, 1, 9});
    check("reset");
    rst_n = 1'b1;

    // Table vectors: phase boundaries and countdown values.
    for (int i = 0; i < 10; i++) begin
      bus.hold = vt[i].hold;
      clk_n(vt[i].adv);
      eff += vt[i].adv;
      sb.push_back(vt[i].e);
      check($sformatf("vec%0d", i));
    end

    // Two full cycles, every clock against the model.
    for (int i = 0; i < 128; i++) begin
      clk_n(1);
      eff++;
      sb.push_back(model(eff));
      check("cycle");
    end

    // Hold across the tick cycle (pre==3): nothing moves until release.
    clk_n(3);
    eff += 3;
    sb.push_back(model(eff));
    check("pre_hold");
    bus.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_n(1);
      sb.push_back(model(eff));
      check("hold");
    end
    bus.hold = 1'b0;
    clk_n(1);
    eff++;
    sb.push_back(model(eff));
    check("hold_release");

    // Reach EW_G with rem=3, then a sub-cycle reset pulse.
    clk_n(40);
    eff += 40;
    sb.push_back('{4, 3'b100, 3'b001, 6, 3});
    check("ew_g_rem3");
    #1 rst_n = 1'b0;
    #2;
    sb.push_back('{0, 3'b100, 3'b100, 1, 9});
    check("async_reset");
    #1 rst_n = 1'b1;
    eff = 0;
    for (int i = 0; i < 8; i++) begin
      clk_n(1);
      eff++;
      sb.push_back(model(eff));
      check("post_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_ctrl.md
Name: traffic_ctrl

Overview:
- Two-way intersection sequencer (north-south / east-west) clocked from the 1 kHz display clock.
- Runs the light-phase state machine with per-second countdowns.
- Drives the lamp outputs and the six BCD digit inputs of the 6-digit multiplexed seven-segment display driver.
- Digit codes 4'hA..4'hF mean "digit blank" at the display driver.

Parameters:
- CLK_HZ, 1000: CLK1K cycles per second tick.
- T_GREEN, 25: green phase length in seconds.
- T_YELLOW, 3: yellow phase length in seconds.
- T_ALLRED, 2: all-red clearance length in seconds.
- Legality: all phase lengths ≥1. 2*T_ALLRED+T_GREEN+T_YELLOW ≤ 99; elaboration error otherwise.

Ports:
- CLK1K  in  1  system clock (1 kHz)
- rst_n  in  1  async active-low reset
- hold  in  1  freeze: prescaler and countdown stop, state held
- ns_light  out  3  {red,yellow,green} north-south lamps
- ew_light  out  3  {red,yellow,green} east-west lamps
- num_1  out  4  NS countdown units (BCD)
- num_2  out  4  NS countdown tens (BCD, 4'hA when tens=0)
- num_3  out  4  always 4'hA (blank separator)
- num_4  out  4  EW countdown units (BCD)
- num_5  out  4  EW countdown tens (BCD, 4'hA when tens=0)
- num_6  out  4  phase index 0..5

Behaviour:
- One clock, CLK1K. Reset is asynchronous, active-low on rst_n. All state is registered; outputs are combinational decode of the registers.
- Prescaler `pre` counts 0..CLK_HZ-1. `tick` = (pre==CLK_HZ-1) && !hold. `pre` wraps to 0 on tick and is frozen while hold=1.
- States and phase index:
  - AR_A 0: both lamps red
  - NS_G 1: NS green
  - NS_Y 2: NS yellow
  - AR_B 3: both lamps red
  - EW_G 4: EW green
  - EW_Y 5: EW yellow
  - While one direction is green or yellow, the other is red.
- Each state has a seconds counter `rem`, loaded with that state's length on entry. On tick:
  - rem>1: decrement.
  - rem==1: advance to the next state and load its length.
  - Sequence: AR_A→NS_G→NS_Y→AR_B→EW_G→EW_Y→AR_A.
- Displayed countdowns:
  - Active (green/yellow) direction shows rem.
  - Red direction shows seconds until its own green starts:
    - NS_G: EW = rem+T_YELLOW+T_ALLRED
    - NS_Y: EW = rem+T_ALLRED
    - AR_B: EW = rem; NS = rem+T_GREEN+T_YELLOW+T_ALLRED
    - EW_G / EW_Y / AR_A: mirror image of the above.
  - Values 1..99 are converted to BCD. Tens=0 is blanked with 4'hA.
- Reset state: AR_A, rem=T_ALLRED, pre=0, ns_light=ew_light=3'b100, num_6=0.
  - With defaults: NS shows 2 (num_2=A, num_1=2); EW shows 32 (num_5=3, num_4=2).
- hold asserted on the tick cycle: tick suppressed; `pre` stays at CLK_HZ-1; the tick fires on the first cycle after release.
- Reset mid-phase: immediate return to reset state.
- No lamp glitches: lamp outputs change only on the tick edge.

Optional Feature:
- Macro TRAFFIC_NIGHT_FLASH_EN.
- Defined:
  - Adds input `night` (1 bit).
  - night=1 forces the FLASH state (phase index 6) on the next clock from any state.
  - In FLASH, both lamps are {0,blink,0}. `blink` toggles on each tick and resets to 1 on FLASH entry. hold is ignored in FLASH.
  - All num_x are 4'hA.
  - night=0 in FLASH: next clock enters AR_A with rem=T_ALLRED and pre=0.
- Undefined: no `night` port, no FLASH state, 6-state machine only.

Decomposition:
- Package traffic_pkg: state encoding constants (AR_A..EW_Y, FLASH), lamp constants (LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001, LAMP_OFF), DIGIT_BLANK=4'hA.
- One sub-module, bin2bcd_99: 7-bit binary to tens/units BCD, combinational.
  - Instantiated twice (NS, EW).
  - Applies tens-blanking.

Test Plan (CLK_HZ=4, T_GREEN=5, T_YELLOW=2, T_ALLRED=1):
- Reset release → AR_A; NS=1, EW=9; lamps 100/100; after 4 cycles NS_G; ns_light=001, NS=5, EW=8.
- Full cycle → phases 0,1,2,3,4,5,0 with dwells of 4,20,8,4,20,8 clocks; total 64 clocks; sequence repeats identically.
- NS_Y with rem=2 → EW shows 3; after one tick, rem=1 and EW=2.
- hold=1 for 10 cycles spanning pre==3 → no state or rem change; tick occurs 1 cycle after release.
- rst_n low during EW_G rem=3, pulse shorter than one clock → outputs return to reset values asynchronously.
- With TRAFFIC_NIGHT_FLASH_EN: night=1 in NS_G → next clock FLASH, all digits A, yellow toggling every 4 clocks; night=0 → AR_A with NS=1.
